// File: rtl/flow_key_extractor_if.sv
// Beat stream in, flow key out: the extractor's handshake bundle.
interface flow_key_extractor_if #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned LEN_WIDTH  = 16
);
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_last;
    logic [LEN_WIDTH-1:0]  s_len;
    logic                  s_ready;

    logic [103:0]          m_key;
    logic [LEN_WIDTH-1:0]  m_len;
    logic                  m_valid;
    logic                  m_ready;

    // Environment side: sources beats, sinks keys.
    modport master (
        output s_data, s_valid, s_last, s_len, m_ready,
        input  s_ready, m_key, m_len, m_valid
    );

    // Extractor side.
    modport slave (
        input  s_data, s_valid, s_last, s_len, m_ready,
        output s_ready, m_key, m_len, m_valid
    );
endinterface

// File: rtl/flow_key_extractor.sv
// 5-tuple flow key extractor: Ethernet (+ optional 802.1Q) / IPv4 / TCP-UDP ports.
module flow_key_extractor #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned LEN_WIDTH  = 16,
    parameter int unsigned VLAN_EN    = 1,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                 memclk,
    input  logic                 reset,
    flow_key_extractor_if.slave  bus,
    output logic [CNT_WIDTH-1:0] stat_ipv4,
    output logic [CNT_WIDTH-1:0] stat_nonip,
    output logic [CNT_WIDTH-1:0] stat_runt
);
    localparam int unsigned B      = DATA_WIDTH / 8;
    localparam int unsigned HB     = 42;
    localparam int unsigned HBEATS = (HB + B - 1) / B;
    localparam int unsigned CNTW   = $clog2(HBEATS + 1);

    typedef enum logic [2:0] {IDLE, HDR, BODY, PARSE, EMIT} state_t;

    state_t              state, state_next;
    logic [HB-1:0][7:0]  hdr;
    logic [CNTW-1:0]     beat_cnt;
    logic [CNTW-1:0]     wr_beat;
    logic [LEN_WIDTH-1:0] len_q;

    logic accept, hdr_done;
    logic hdr_we, len_we, cnt_inc, key_load, key_clear, runt_inc, nonip_inc;

    logic        vlan;
    logic [15:0] eth_type;
    logic [3:0]  ihl;
    logic [7:0]  proto;
    logic [31:0] src_ip, dst_ip;
    logic [15:0] src_port, dst_port;
    logic        ports_ok;
    logic        unused_bits;

    assign accept      = bus.s_valid && bus.s_ready;
    assign hdr_done    = (32'(beat_cnt) + 32'd1) >= HBEATS;
    assign unused_bits = ^{hdr, bus.s_data};

    // Field decode from the header buffer, shifted by 4 bytes when a VLAN tag is present.
    always_comb begin
        vlan     = (VLAN_EN != 0) && ({hdr[12], hdr[13]} == 16'h8100);
        eth_type = vlan ? {hdr[16], hdr[17]} : {hdr[12], hdr[13]};
        ihl      = vlan ? hdr[18][3:0] : hdr[14][3:0];
        proto    = vlan ? hdr[27] : hdr[23];
        src_ip   = vlan ? {hdr[30], hdr[31], hdr[32], hdr[33]} : {hdr[26], hdr[27], hdr[28], hdr[29]};
        dst_ip   = vlan ? {hdr[34], hdr[35], hdr[36], hdr[37]} : {hdr[30], hdr[31], hdr[32], hdr[33]};
        src_port = vlan ? {hdr[38], hdr[39]} : {hdr[34], hdr[35]};
        dst_port = vlan ? {hdr[40], hdr[41]} : {hdr[36], hdr[37]};
        ports_ok = ((proto == 8'd6) || (proto == 8'd17)) && (ihl == 4'd5);
        if (!ports_ok) begin
            src_port = 16'h0000;
            dst_port = 16'h0000;
        end
    end

    // State register.
    always_ff @(posedge memclk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state and datapath strobes.
    always_comb begin
        state_next = state;
        hdr_we     = 1'b0;
        wr_beat    = '0;
        len_we     = 1'b0;
        cnt_inc    = 1'b0;
        key_load   = 1'b0;
        key_clear  = 1'b0;
        runt_inc   = 1'b0;
        nonip_inc  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    hdr_we = 1'b1;
                    len_we = 1'b1;
                    if (bus.s_last) begin
                        if (HBEATS == 1) state_next = PARSE;
                        else             runt_inc   = 1'b1;
                    end else begin
                        state_next = (HBEATS > 1) ? HDR : BODY;
                    end
                end
            end
            HDR: begin
                if (accept) begin
                    hdr_we  = 1'b1;
                    wr_beat = beat_cnt;
                    cnt_inc = 1'b1;
                    if (hdr_done) begin
                        state_next = bus.s_last ? PARSE : BODY;
                    end else if (bus.s_last) begin
                        runt_inc   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            BODY: begin
                if (accept && bus.s_last) state_next = PARSE;
            end
            PARSE: begin
                if (eth_type == 16'h0800) begin
                    key_load   = 1'b1;
                    state_next = EMIT;
                end else begin
                    nonip_inc  = 1'b1;
                    state_next = IDLE;
                end
            end
            EMIT: begin
                if (bus.m_ready) begin
                    key_clear  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Header buffer: beat k lands on bytes [k*B, k*B+B-1], bytes past 41 dropped.
    always_ff @(posedge memclk) begin
        if (reset) begin
            hdr <= '0;
        end else if (hdr_we) begin
            for (int j = 0; j < int'(HB); j++) begin
                if (wr_beat == CNTW'(j / int'(B))) hdr[j] <= bus.s_data[8*(j % int'(B)) +: 8];
            end
        end
    end

    // Beat counter and packet length capture.
    always_ff @(posedge memclk) begin
        if (reset) begin
            beat_cnt <= '0;
            len_q    <= '0;
        end else begin
            if (len_we) begin
                beat_cnt <= CNTW'(1);
                len_q    <= bus.s_len;
            end else if (cnt_inc) begin
                beat_cnt <= beat_cnt + CNTW'(1);
            end
        end
    end

    // Key output port and input ready, both registered.
    always_ff @(posedge memclk) begin
        if (reset) begin
            bus.m_key   <= '0;
            bus.m_len   <= '0;
            bus.m_valid <= 1'b0;
            bus.s_ready <= 1'b1;
        end else begin
            if (key_load) begin
                bus.m_key   <= {src_ip, dst_ip, src_port, dst_port, proto};
                bus.m_len   <= len_q;
                bus.m_valid <= 1'b1;
            end else if (key_clear) begin
                bus.m_valid <= 1'b0;
            end
            bus.s_ready <= (state_next == IDLE) || (state_next == HDR) || (state_next == BODY);
        end
    end

    // Statistics counters, wrapping.
    always_ff @(posedge memclk) begin
        if (reset) begin
            stat_ipv4  <= '0;
            stat_nonip <= '0;
            stat_runt  <= '0;
        end else begin
            if (key_load)  stat_ipv4  <= stat_ipv4  + CNT_WIDTH'(1);
            if (nonip_inc) stat_nonip <= stat_nonip + CNT_WIDTH'(1);
            if (runt_inc)  stat_runt  <= stat_runt  + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_flow_key_extractor.sv
// Directed bench: a 256-bit VLAN-aware instance and a 64-bit VLAN-blind instance.
module tb_flow_key_extractor;
    logic memclk = 1'b0;
    logic reset  = 1'b1;

    flow_key_extractor_if #(.DATA_WIDTH(256), .LEN_WIDTH(16)) wif ();
    flow_key_extractor_if #(.DATA_WIDTH(64),  .LEN_WIDTH(16)) nif ();

    logic [31:0] w_ipv4, w_nonip, w_runt;
    logic [31:0] n_ipv4, n_nonip, n_runt;

    flow_key_extractor #(.DATA_WIDTH(256), .LEN_WIDTH(16), .VLAN_EN(1), .CNT_WIDTH(32)) u_wide (
        .memclk(memclk), .reset(reset), .bus(wif),
        .stat_ipv4(w_ipv4), .stat_nonip(w_nonip), .stat_runt(w_runt)
    );

    flow_key_extractor #(.DATA_WIDTH(64), .LEN_WIDTH(16), .VLAN_EN(0), .CNT_WIDTH(32)) u_narrow (
        .memclk(memclk), .reset(reset), .bus(nif),
        .stat_ipv4(n_ipv4), .stat_nonip(n_nonip), .stat_runt(n_runt)
    );

    always #5 memclk = ~memclk;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] pkt [128];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic build(input bit vlan, input logic [15:0] etype, input logic [7:0] vihl,
                         input logic [7:0] proto, input logic [31:0] src, input logic [31:0] dst,
                         input logic [15:0] sp, input logic [15:0] dp);
        int v;
        v = vlan ? 4 : 0;
        for (int i = 0; i < 128; i++) pkt[i] = 8'(i * 7 + 3);
        if (vlan) begin
            pkt[12] = 8'h81; pkt[13] = 8'h00; pkt[14] = 8'h00; pkt[15] = 8'h05;
        end
        pkt[12+v] = etype[15:8]; pkt[13+v] = etype[7:0];
        pkt[14+v] = vihl;        pkt[23+v] = proto;
        pkt[26+v] = src[31:24];  pkt[27+v] = src[23:16]; pkt[28+v] = src[15:8]; pkt[29+v] = src[7:0];
        pkt[30+v] = dst[31:24];  pkt[31+v] = dst[23:16]; pkt[32+v] = dst[15:8]; pkt[33+v] = dst[7:0];
        pkt[34+v] = sp[15:8];    pkt[35+v] = sp[7:0];
        pkt[36+v] = dp[15:8];    pkt[37+v] = dp[7:0];
    endtask

    // Sends the first nsend beats of an nbytes packet; returns just after the last accept edge.
    task automatic send(input bit narrow, input int nbytes, input logic [15:0] len, input int nsend);
        int bw, nbeats, guard;
        bw     = narrow ? 8 : 32;
        nbeats = (nbytes + bw - 1) / bw;
        for (int b = 0; b < nsend; b++) begin
            @(negedge memclk);
            if (narrow) begin
                for (int i = 0; i < 8; i++) nif.s_data[8*i +: 8] = pkt[b*8 + i];
                nif.s_valid = 1'b1; nif.s_last = (b == nbeats - 1); nif.s_len = len;
            end else begin
                for (int i = 0; i < 32; i++) wif.s_data[8*i +: 8] = pkt[b*32 + i];
                wif.s_valid = 1'b1; wif.s_last = (b == nbeats - 1); wif.s_len = len;
            end
            guard = 0;
            while (!(narrow ? nif.s_ready : wif.s_ready) && guard < 100) begin
                @(negedge memclk);
                guard++;
            end
            if (guard >= 100) check("send_timeout", 128'(guard), 128'(0));
            @(posedge memclk);
        end
    endtask

    task automatic idle_inputs();
        wif.s_valid = 1'b0; wif.s_last = 1'b0;
        nif.s_valid = 1'b0; nif.s_last = 1'b0;
    endtask

    // Expect a key two cycles after the final accepted beat.
    task automatic expect_key(input bit narrow, input string tag, input logic [103:0] key, input logic [15:0] len);
        @(negedge memclk);
        idle_inputs();
        check({tag, "_parse_valid"}, 128'(narrow ? nif.m_valid : wif.m_valid), 128'(0));
        check({tag, "_parse_ready"}, 128'(narrow ? nif.s_ready : wif.s_ready), 128'(0));
        @(negedge memclk);
        check({tag, "_valid"}, 128'(narrow ? nif.m_valid : wif.m_valid), 128'(1));
        check({tag, "_key"},   128'(narrow ? nif.m_key   : wif.m_key),   128'(key));
        check({tag, "_len"},   128'(narrow ? nif.m_len   : wif.m_len),   128'(len));
    endtask

    // Expect a non-IPv4 drop: ready low for the parse cycle only, no key.
    task automatic expect_drop(input bit narrow, input string tag);
        @(negedge memclk);
        idle_inputs();
        check({tag, "_parse_ready"}, 128'(narrow ? nif.s_ready : wif.s_ready), 128'(0));
        @(negedge memclk);
        check({tag, "_ready_back"}, 128'(narrow ? nif.s_ready : wif.s_ready), 128'(1));
        check({tag, "_no_key"},     128'(narrow ? nif.m_valid : wif.m_valid), 128'(0));
    endtask

    initial begin
        wif.s_data = '0; wif.s_len = '0; wif.m_ready = 1'b1;
        nif.s_data = '0; nif.s_len = '0; nif.m_ready = 1'b1;
        idle_inputs();
        repeat (3) @(negedge memclk);
        reset = 1'b0;

        // Reset state
        check("rst_wide_ready", 128'(wif.s_ready), 128'(1));
        check("rst_wide_valid", 128'(wif.m_valid), 128'(0));
        check("rst_wide_key",   128'(wif.m_key),   128'(0));
        check("rst_wide_stats", 128'({w_ipv4, w_nonip, w_runt}), 128'(0));
        check("rst_narrow_ready", 128'(nif.s_ready), 128'(1));

        // Narrow: runt of 4 beats (32 bytes) before the 6-beat header completes
        build(0, 16'h0800, 8'h45, 8'd6, 32'hC0A8010A, 32'hAC100001, 16'd5353, 16'd443);
        send(1, 32, 16'd32, 4);
        @(negedge memclk);
        idle_inputs();
        check("runt_count", 128'(n_runt),      128'(1));
        check("runt_ready", 128'(nif.s_ready), 128'(1));
        @(negedge memclk);
        check("runt_no_key", 128'(nif.m_valid), 128'(0));

        // Narrow: following valid TCP packet parses cleanly
        send(1, 64, 16'd64, 8);
        expect_key(1, "n_tcp", 104'hC0A8010A_AC100001_14E9_01BB_06, 16'd64);

        // Narrow: IHL 6 forces ports to zero
        build(0, 16'h0800, 8'h46, 8'd17, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80);
        send(1, 64, 16'd64, 8);
        expect_key(1, "n_ihl6", 104'h0A000001_0A000002_0000_0000_11, 16'd64);

        // Narrow: ICMP, ports zero
        build(0, 16'h0800, 8'h45, 8'd1, 32'h01010101, 32'h02020202, 16'd7, 16'd9);
        send(1, 64, 16'd64, 8);
        expect_key(1, "n_icmp", 104'h01010101_02020202_0000_0000_01, 16'd64);

        // Narrow: VLAN tag with VLAN support off is non-IPv4
        build(1, 16'h0800, 8'h45, 8'd17, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80);
        send(1, 68, 16'd68, 9);
        expect_drop(1, "n_vlan");
        check("n_stats", 128'({n_ipv4, n_nonip, n_runt}), 128'({32'd3, 32'd1, 32'd1}));

        // Wide: basic IPv4/TCP
        build(0, 16'h0800, 8'h45, 8'd6, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80);
        send(0, 64, 16'd64, 2);
        expect_key(0, "w_tcp", 104'h0A000001_0A000002_04D2_0050_06, 16'd64);
        check("w_tcp_cnt", 128'(w_ipv4), 128'(1));

        // Wide: VLAN-tagged UDP
        build(1, 16'h0800, 8'h45, 8'd17, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80);
        send(0, 68, 16'd68, 3);
        expect_key(0, "w_vlan", 104'h0A000001_0A000002_04D2_0050_11, 16'd68);

        // Wide: ARP
        build(0, 16'h0806, 8'h45, 8'd6, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80);
        send(0, 64, 16'd64, 2);
        expect_drop(0, "w_arp");
        check("w_arp_cnt", 128'(w_nonip), 128'(1));

        // Wide: downstream stall with a next packet waiting
        wif.m_ready = 1'b0;
        build(0, 16'h0800, 8'h45, 8'd6, 32'h0A010203, 32'h0A040506, 16'd1000, 16'd2000);
        send(0, 64, 16'd64, 2);
        expect_key(0, "w_stall", 104'h0A010203_0A040506_03E8_07D0_06, 16'd64);
        build(0, 16'h0800, 8'h45, 8'd17, 32'h08080808, 32'h0A000009, 16'd53, 16'd40000);
        for (int i = 0; i < 32; i++) wif.s_data[8*i +: 8] = pkt[i];
        wif.s_valid = 1'b1; wif.s_last = 1'b0; wif.s_len = 16'd100;
        for (int c = 0; c < 20; c++) begin
            @(negedge memclk);
            check("stall_valid", 128'(wif.m_valid), 128'(1));
            check("stall_key",   128'(wif.m_key),   128'(104'h0A010203_0A040506_03E8_07D0_06));
            check("stall_len",   128'(wif.m_len),   128'(16'd64));
            check("stall_ready", 128'(wif.s_ready), 128'(0));
        end
        wif.m_ready = 1'b1;
        send(0, 100, 16'd100, 4);
        expect_key(0, "w_b2b", 104'h08080808_0A000009_0035_9C40_11, 16'd100);
        check("w_b2b_cnt", 128'(w_ipv4), 128'(4));

        // Wide: reset in the body of packet A, then packet B
        build(0, 16'h0800, 8'h45, 8'd6, 32'hDEADBEEF, 32'hCAFEF00D, 16'd11, 16'd22);
        send(0, 128, 16'd128, 3);
        @(negedge memclk);
        idle_inputs();
        reset = 1'b1;
        repeat (2) @(negedge memclk);
        reset = 1'b0;
        check("rst2_stats", 128'({w_ipv4, w_nonip, w_runt}), 128'(0));
        check("rst2_ready", 128'(wif.s_ready), 128'(1));
        check("rst2_valid", 128'(wif.m_valid), 128'(0));
        build(0, 16'h0800, 8'h45, 8'd6, 32'h01020304, 32'h05060708, 16'd1, 16'd2);
        send(0, 60, 16'd60, 2);
        expect_key(0, "w_after_rst", 104'h01020304_05060708_0001_0002_06, 16'd60);
        check("w_after_rst_cnt", 128'(w_ipv4), 128'(1));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
